testro_rst_pulse_master: RTL

//  Avalon-MM initiator that drives the 1-bit external-reset PIO slave (s1) to produce a timed reset pulse.
//  On a start request: writes 1 to the PIO data register, holds for PULSE_CYCLES, then writes 0.

---
 rtl/testro_rst_pulse_master_if.sv | 28 ++
 rtl/testro_rst_pulse_master.sv | 136 +++++++++++++
 2 files changed

// File: rtl/testro_rst_pulse_master_if.sv
// Avalon-MM bus between the reset-pulse initiator and the 1-bit ext_rst PIO slave.
// There is no waitrequest: every access completes in the cycle it is presented.
interface testro_rst_pulse_master_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect;
    logic              m_write_n;
    logic [DATA_W-1:0] m_writedata;
    logic [DATA_W-1:0] m_readdata;

    modport master (
        output m_address,
        output m_chipselect,
        output m_write_n,
        output m_writedata,
        input  m_readdata
    );

    modport slave (
        input  m_address,
        input  m_chipselect,
        input  m_write_n,
        input  m_writedata,
        output m_readdata
    );
endinterface

// File: rtl/testro_rst_pulse_master.sv
// testro_rst_pulse_master: Avalon-MM initiator that writes 1 and later 0 to the
// ext_rst PIO data register, producing a reset pulse held for PULSE_CYCLES
// cycles. With VERIFY=1 each write is read back and a mismatch sets a sticky
// error flag, which never aborts the sequence.
module testro_rst_pulse_master #(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int RST_ADDR     = 0,
    parameter int PULSE_CYCLES = 16,
    parameter int VERIFY       = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    testro_rst_pulse_master_if.master  bus
);

    localparam int                CNT_W     = $clog2(PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ACC_ADDR  = ADDR_W'(RST_ADDR);
    localparam logic [DATA_W-1:0] SET_VAL   = DATA_W'(1);

    if (PULSE_CYCLES < 1 || PULSE_CYCLES > 65535) begin : g_bad_pulse_cycles
        $error("testro_rst_pulse_master: PULSE_CYCLES must lie in 1..65535");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SET,
        S_RD_SET,
        S_HOLD,
        S_WR_CLR,
        S_RD_CLR,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              error_q, error_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              cs_q,    cs_d;
    logic              wn_q,    wn_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // Next state, hold counter and read-back check; bus outputs are decoded
    // from the next state so the registered outputs line up with the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        error_d = error_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WR_SET;
                    error_d = 1'b0;
                end
            end
            S_WR_SET: state_d = (VERIFY != 0) ? S_RD_SET : S_HOLD;
            S_RD_SET: begin
                state_d = S_HOLD;
                if (bus.m_readdata != SET_VAL) begin
                    error_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_WR_CLR;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WR_CLR: state_d = (VERIFY != 0) ? S_RD_CLR : S_DONE;
            S_RD_CLR: begin
                state_d = S_DONE;
                if (bus.m_readdata != '0) begin
                    error_d = 1'b1;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (state_d == S_HOLD && state_q != S_HOLD) begin
            cnt_d = HOLD_LOAD;
        end

        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        cs_d    = (state_d == S_WR_SET) || (state_d == S_RD_SET) ||
                  (state_d == S_WR_CLR) || (state_d == S_RD_CLR);
        wn_d    = !((state_d == S_WR_SET) || (state_d == S_WR_CLR));
        wdata_d = (state_d == S_WR_SET) ? SET_VAL : '0;
        addr_d  = cs_d ? ACC_ADDR : '0;
    end

    // State and output registers; reset drops any in-flight access without
    // touching the PIO value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;
    assign bus.m_chipselect = cs_q;
    assign bus.m_write_n    = wn_q;
    assign bus.m_address    = addr_q;
    assign bus.m_writedata  = wdata_q;

endmodule
